// File: rtl/leds.sv
// ---------------------------------------------------------------------------
// leds -- memory-mapped LED output peripheral.
//
// Latches 16-bit CPU store data into a 24-bit LED register, drives the board
// LEDs, offers a hardware blink mode, and returns register contents over the
// 16-bit data bus. All state changes on the falling edge of ledclk so that
// the CPU, which works on the rising edge, sees stable read data.
//
// Register map (ledaddr):
//   00  led_reg[15:0]             read/write
//   01  reserved                  writes ignored, reads hold ledrdata
//   10  led_reg[23:16]            read/write (upper byte of bus ignored)
//   11  blink control, bit 0      read/write; every write restarts blinking
//
// Ports:
//   ledclk    in   1   clock, falling-edge active
//   ledrst    in   1   synchronous active-high reset
//   ledcs     in   1   chip select from memory/IO decoder
//   ledaddr   in   2   register select
//   ledwrite  in   1   write strobe (qualified by ledcs)
//   ledread   in   1   read strobe (qualified by ledcs)
//   ledwdata  in  16   store data
//   ledrdata  out 16   registered readback data
//   led_o     out 24   board LED drive, bit 23 leftmost
// ---------------------------------------------------------------------------
module leds #(
  parameter int unsigned BLINK_DIV = 25000000  // ledclk cycles per half-period, 2..2^26-1
) (
  input  logic        ledclk,
  input  logic        ledrst,
  input  logic        ledcs,
  input  logic [1:0]  ledaddr,
  input  logic        ledwrite,
  input  logic        ledread,
  input  logic [15:0] ledwdata,
  output logic [15:0] ledrdata,
  output logic [23:0] led_o
);

  typedef enum logic [1:0] {
    ADDR_LOW  = 2'b00,
    ADDR_RSVD = 2'b01,
    ADDR_HIGH = 2'b10,
    ADDR_CTRL = 2'b11
  } reg_addr_t;

  localparam logic [25:0] CNT_LAST = 26'(BLINK_DIV - 1);

  logic [23:0] led_reg;
  logic        blink_en;
  logic [25:0] blink_cnt;
  logic        phase;      // 1 = LEDs shown, 0 = blanked

  reg_addr_t   addr;
  logic        wr_q;
  logic        rd_q;
  logic        ctrl_wr;

  assign addr    = reg_addr_t'(ledaddr);
  assign wr_q    = ledcs & ledwrite;
  assign rd_q    = ledcs & ledread;
  assign ctrl_wr = wr_q && (addr == ADDR_CTRL);

  // NOTE: non-blocking assignments make every right-hand side see the value
  // from before this edge, which is exactly what gives a same-edge read the
  // pre-write register contents.
  always_ff @(negedge ledclk) begin
    if (ledrst) begin
      led_reg   <= '0;
      blink_en  <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      ledrdata  <= '0;
    end else begin
      // Readback; reserved address and unqualified cycles hold ledrdata.
      if (rd_q) begin
        case (addr)
          ADDR_LOW:  ledrdata <= led_reg[15:0];
          ADDR_HIGH: ledrdata <= {8'h00, led_reg[23:16]};
          ADDR_CTRL: ledrdata <= {15'b0, blink_en};
          default:   ledrdata <= ledrdata;
        endcase
      end

      if (wr_q) begin
        case (addr)
          ADDR_LOW:  led_reg[15:0]  <= ledwdata;
          ADDR_HIGH: led_reg[23:16] <= ledwdata[7:0];
          default:   led_reg        <= led_reg;
        endcase
      end

      // A control write always restarts the blink sequence in the "on" phase,
      // even when it rewrites the current enable value.
      if (ctrl_wr) begin
        blink_en  <= ledwdata[0];
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_en) begin
        if (blink_cnt == CNT_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 26'd1;
        end
      end else begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end
    end
  end

  // Purely a function of registered state, so stable between falling edges.
  assign led_o = led_reg & {24{phase | ~blink_en}};

endmodule

// File: tb/tb_leds.sv
// ---------------------------------------------------------------------------
// tb_leds -- self-checking bench for the leds peripheral (BLINK_DIV = 4).
//
// A behavioural model tracks the LED value, the blink enable and the number
// of edges elapsed since the last control write; blanking is derived from
// that elapsed count. The model is compared against the DUT shortly after
// every falling edge, and a directed sequence pins the model with literal
// expectations before a randomized run.
// ---------------------------------------------------------------------------
module tb_leds;

  localparam int BD = 4;

  logic        ledclk;
  logic        ledrst;
  logic        ledcs;
  logic [1:0]  ledaddr;
  logic        ledwrite;
  logic        ledread;
  logic [15:0] ledwdata;
  logic [15:0] ledrdata;
  logic [23:0] led_o;

  leds #(.BLINK_DIV(BD)) dut (
    .ledclk   (ledclk),
    .ledrst   (ledrst),
    .ledcs    (ledcs),
    .ledaddr  (ledaddr),
    .ledwrite (ledwrite),
    .ledread  (ledread),
    .ledwdata (ledwdata),
    .ledrdata (ledrdata),
    .led_o    (led_o)
  );

  initial ledclk = 1'b1;
  always #5 ledclk = ~ledclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_led;
  logic        m_en;
  int          m_since;   // edges since the last control write
  logic [15:0] m_rdata;
  logic        m_valid = 1'b0;

  function automatic logic [23:0] model_led();
    if (m_en && (((m_since / BD) % 2) == 1)) return 24'h0;
    return m_led;
  endfunction

  task automatic model_update();
    logic ctrl;
    if (ledrst) begin
      m_led   = '0;
      m_en    = 1'b0;
      m_since = 0;
      m_rdata = '0;
      m_valid = 1'b1;
      return;
    end
    if (ledcs && ledread) begin
      if (ledaddr == 2'b00)      m_rdata = m_led[15:0];
      else if (ledaddr == 2'b10) m_rdata = {8'h00, m_led[23:16]};
      else if (ledaddr == 2'b11) m_rdata = {15'b0, m_en};
    end
    ctrl = ledcs && ledwrite && (ledaddr == 2'b11);
    if (ledcs && ledwrite) begin
      if (ledaddr == 2'b00) m_led[15:0]  = ledwdata;
      if (ledaddr == 2'b10) m_led[23:16] = ledwdata[7:0];
    end
    if (ctrl) begin
      m_en    = ledwdata[0];
      m_since = 0;
    end else if (m_en) begin
      m_since++;
    end else begin
      m_since = 0;
    end
  endtask

  always @(negedge ledclk) begin
    model_update();
    #1;
    if (m_valid) begin
      check("model_led_o", {8'h0, led_o}, {8'h0, model_led()});
      check("model_rdata", {16'h0, ledrdata}, {16'h0, m_rdata});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rst, input logic cs, input logic wr, input logic rd,
                      input logic [1:0] addr, input logic [15:0] wd);
    ledrst   = rst;
    ledcs    = cs;
    ledwrite = wr;
    ledread  = rd;
    ledaddr  = addr;
    ledwdata = wd;
    @(negedge ledclk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
  endtask

  localparam logic [23:0] PAT = 24'hF7A5C3;

  initial begin
    ledrst = 1'b1; ledcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
    ledaddr = 2'b00; ledwdata = 16'h0000;

    // Reset with a concurrent write attempt.
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF);
    check("reset_led_o", {8'h0, led_o}, 32'h0);
    check("reset_rdata", {16'h0, ledrdata}, 32'h0);

    // Halfword writes and readback.
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'hA5C3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 16'h12F7);
    check("hw_write_led_o", {8'h0, led_o}, {8'h0, PAT});
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 16'h0000);
    check("read_hi", {16'h0, ledrdata}, 32'h0000_00F7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000);
    check("read_lo", {16'h0, ledrdata}, 32'h0000_A5C3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0000);
    check("read_rsvd_holds", {16'h0, ledrdata}, 32'h0000_A5C3);

    // Chip select gating.
    step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'h0000);
    check("cs_gate_led_o", {8'h0, led_o}, {8'h0, PAT});

    // Blink: on for 4 edges, off for 4, on again.
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0001);
    check("blink_e0", {8'h0, led_o}, {8'h0, PAT});
    for (int i = 1; i <= 8; i++) begin
      idle();
      check($sformatf("blink_e%0d", i), {8'h0, led_o},
            {8'h0, ((i >= 4) && (i < 8)) ? 24'h0 : PAT});
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0000);   // edge 9
    check("read_ctrl", {16'h0, ledrdata}, 32'h0000_0001);
    for (int i = 10; i <= 12; i++) idle();
    check("second_off_phase", {8'h0, led_o}, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0000);
    check("disable_led_o", {8'h0, led_o}, {8'h0, PAT});
    idle();
    check("disable_stays", {8'h0, led_o}, {8'h0, PAT});

    // Same-edge read and write.
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0F0F);
    check("rw_rdata_old", {16'h0, ledrdata}, 32'h0000_A5C3);
    check("rw_led_new", {16'h0, led_o[15:0]}, 32'h0000_0F0F);

    // Re-arm at blink_cnt == 2, then reset mid-off-phase.
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0001);
    idle();
    idle();
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0001);
    for (int i = 1; i <= 3; i++) begin
      idle();
      check($sformatf("rearm_on_%0d", i), {8'h0, led_o}, 32'h00F7_0F0F);
    end
    idle();
    check("rearm_off", {8'h0, led_o}, 32'h0);
    idle();
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000);
    check("midrst_led_o", {8'h0, led_o}, 32'h0);
    check("midrst_rdata", {16'h0, ledrdata}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0000);
    check("midrst_blink_en", {16'h0, ledrdata}, 32'h0);

    // Randomized traffic; the per-edge model comparison does the checking.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)),
           16'($urandom));
      // Let blinking run for a while between bursts.
      if ($urandom_range(0, 15) == 0)
        for (int j = 0; j < 10; j++) idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/leds.md
Name: leds

Overview:
- Memory-mapped LED output peripheral: the CPU-write counterpart of the switch input port.
- Sits behind the memory/IO decoder.
- Latches 16-bit CPU store data into a 24-bit LED register and drives the board LEDs.
- Provides a hardware blink mode and readback of its registers over the 16-bit data bus.

Parameters:
- BLINK_DIV, 25000000, ledclk cycles per blink half-period; legal range 2..2^26-1.

Ports:
- ledclk  input  1  clock; all state updates on the falling edge.
- ledrst  input  1  reset; synchronous, active-high.
- ledcs  input  1  LED chip select from the memory/IO decoder.
- ledaddr  input  2  low address bits selecting the register.
- ledwrite  input  1  write strobe, qualified by ledcs.
- ledread  input  1  read strobe, qualified by ledcs.
- ledwdata  input  16  store data from CPU.
- ledrdata  output  16  registered readback data to CPU.
- led_o  output  24  board LED drive; bit 23 leftmost.

Behaviour:
- Registers:
  - led_reg[23:0]
  - blink_en (1 bit)
  - blink_cnt (26 bits)
  - phase (1 bit)
  - ledrdata[15:0] (registered)
- Reset (ledrst=1 at a falling edge): led_reg=0, blink_en=0, blink_cnt=0, phase=1, ledrdata=0. Reset overrides any concurrent read or write.
- Write, when ledcs && ledwrite at a falling edge:
  - ledaddr 00: led_reg[15:0] <= ledwdata; led_reg[23:16] unchanged.
  - ledaddr 10: led_reg[23:16] <= ledwdata[7:0]; ledwdata[15:8] ignored; led_reg[15:0] unchanged.
  - ledaddr 11: blink_en <= ledwdata[0]; blink_cnt <= 0; phase <= 1. This applies on every write to 11, including rewriting the same value.
  - ledaddr 01: no effect.
- Read, when ledcs && ledread at a falling edge:
  - ledaddr 00: ledrdata <= led_reg[15:0].
  - ledaddr 10: ledrdata <= {8'h00, led_reg[23:16]}.
  - ledaddr 11: ledrdata <= {15'b0, blink_en}.
  - ledaddr 01: ledrdata holds.
- ledrdata holds its value whenever no read is qualified.
- Simultaneous read and write to the same address: ledrdata gets the pre-write value; the write takes effect at the same edge.
- ledcs=0: ledwrite and ledread are ignored, with no state change.
- Blink counter:
  - When blink_en=1 and no write to 11 occurs that edge: if blink_cnt==BLINK_DIV-1, then blink_cnt<=0 and phase<=~phase; otherwise blink_cnt<=blink_cnt+1.
  - When blink_en=0: blink_cnt<=0 and phase<=1.
- Output: led_o = led_reg & {24{phase | ~blink_en}}. led_o is a purely combinational function of registered state, so it is glitch-free between edges.
- Latency:
  - A write is visible on led_o immediately after the falling edge that captures it.
  - Read data is valid after the falling edge and is sampled by the CPU on the following rising edge.
- Blink timing: the first LEDs-off phase begins BLINK_DIV edges after the enabling write. The period is 2*BLINK_DIV cycles.
- Register updates to led_reg while blinking do not disturb blink_cnt or phase.
- Mid-operation reset: all state returns to reset values at that edge, regardless of counter position.

Test Plan (BLINK_DIV=4 in sim):
- Reset: assert ledrst for 2 edges while ledcs=1, ledwrite=1, ledaddr=00, ledwdata=16'hFFFF -> led_o=24'h000000 and ledrdata=16'h0000.
- Halfword writes:
  - Write 16'hA5C3 to 00, then 16'h12F7 to 10 -> led_o=24'hF7A5C3.
  - Read 10 -> 16'h00F7; read 00 -> 16'hA5C3.
  - Read 01 afterwards -> ledrdata stays 16'hA5C3.
- Chip select gating: ledcs=0 with ledwrite=1, ledaddr=00, ledwdata=16'h0000 -> led_o unchanged at 24'hF7A5C3.
- Blink:
  - Write 16'h0001 to 11 -> led_o=24'hF7A5C3 for 4 edges, then 0 for 4 edges, then 24'hF7A5C3 again; read 11 -> 16'h0001.
  - Write 16'h0000 to 11 during an off phase -> led_o=24'hF7A5C3 at the next edge and stays.
- Concurrent access: same edge read and write at 00 with old value 16'hA5C3 and new 16'h0F0F -> ledrdata=16'hA5C3 and led_o[15:0]=16'h0F0F.
- Re-arm and reset: with blinking at blink_cnt=2, write 16'h0001 to 11 again -> phase=1 and off begins 4 edges later. A ledrst pulse mid-off-phase -> led_o=0, blink_en=0 and ledrdata=0 at the next edge.
